bcd_digit_chain: RTL

//   Cascaded BCD up-counter: prescaler, DIGITS decimal digits, run/stop FSM.
//   Per-digit enable = carry from the stage below (ripple-enable chain).

---
 rtl/bcd_digit_chain_if.sv | 26 ++
 rtl/bcd_digit_chain.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bcd_digit_chain_if.sv
// Handshake bundle for the cascaded BCD counter: control pulses and load value
// in, digit value and status pulses out.
interface bcd_digit_chain_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  stop;
   logic                  clear;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   digits;
   logic                  tick;
   logic                  carry_out;
   logic                  running;
   logic                  ovf;

   modport master (
      output start, stop, clear, load, load_val,
      input  digits, tick, carry_out, running, ovf
   );

   modport slave (
      input  start, stop, clear, load, load_val,
      output digits, tick, carry_out, running, ovf
   );
endinterface

// File: rtl/bcd_digit_chain.sv
// Cascaded BCD up-counter: a prescaler produces count ticks, a ripple-enable
// carry chain advances DIGITS decimal digits, and a run/stop FSM gates it all.
// carry_out feeds the next counter block in a longer chain.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_STOPPED  | prescaler and digits frozen; start moves to ST_RUNNING
//   ST_RUNNING  | prescaler counts, digits advance on each tick
//   ST_OVF      | WRAP=0 only: digits held at all-9, left only by clear/load
module bcd_digit_chain #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 100000,
   parameter int WRAP     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_digit_chain_if.slave  bus
);

   localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC  = PW'(TICK_DIV - 1);
   localparam bit            SATURATE  = (WRAP == 0);

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUNNING = 2'd1,
      ST_OVF     = 2'd2
   } state_t;

   state_t                state;
   logic                  running_q;
   logic                  ovf_q;
   logic [PW-1:0]         presc;
   logic [4*DIGITS-1:0]   dig_q;
   logic [4*DIGITS-1:0]   dig_next;
   logic [4*DIGITS-1:0]   load_sat;
   logic [DIGITS:0]       c;
   logic                  count_en;
   logic                  tick_w;
   logic                  top_ovf;

   // Higher-priority controls (clear, load, stop) suppress counting this
   // cycle, so a tick is only reported when the prescaler really advances.
   assign count_en = (state == ST_RUNNING) & ~bus.clear & ~bus.load & ~bus.stop;
   assign tick_w   = count_en & (presc == PRESC_TC);
   assign top_ovf  = c[DIGITS];

   // Ripple-enable carry chain, increment values and load clamping.
   always_comb begin
      c        = '0;
      dig_next = dig_q;
      load_sat = '0;
      c[0]     = tick_w;
      for (int i = 0; i < DIGITS; i++) begin
         c[i+1] = c[i] & (dig_q[4*i +: 4] == 4'd9);
         if (c[i]) begin
            dig_next[4*i +: 4] = (dig_q[4*i +: 4] == 4'd9) ? 4'd0
                                 : dig_q[4*i +: 4] + 4'd1;
         end
         load_sat[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9
                              : bus.load_val[4*i +: 4];
      end
   end

   // Prescaler: counts 0..TICK_DIV-1 in RUNNING only, frozen otherwise so a
   // stop/start pair loses no cycle of the current interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (bus.clear || bus.load) begin
         presc <= '0;
      end else if (count_en) begin
         presc <= (presc == PRESC_TC) ? '0 : presc + PW'(1);
      end
   end

   // Digit register; in saturate mode the overflowing tick leaves all-9 intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_q <= '0;
      end else if (bus.clear) begin
         dig_q <= '0;
      end else if (bus.load) begin
         dig_q <= load_sat;
      end else if (tick_w && !(SATURATE && top_ovf)) begin
         dig_q <= dig_next;
      end
   end

   // Run/stop/overflow FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_STOPPED;
         running_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (bus.clear || bus.load) begin
         state     <= ST_STOPPED;
         running_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state)
            ST_STOPPED: begin
               if (!bus.stop && bus.start) begin
                  state     <= ST_RUNNING;
                  running_q <= 1'b1;
               end
            end
            ST_RUNNING: begin
               if (bus.stop) begin
                  state     <= ST_STOPPED;
                  running_q <= 1'b0;
               end else if (SATURATE && top_ovf) begin
                  state     <= ST_OVF;
                  running_q <= 1'b0;
                  ovf_q     <= 1'b1;
               end
            end
            ST_OVF: begin
               state     <= ST_OVF;
               running_q <= 1'b0;
               ovf_q     <= 1'b1;
            end
            default: begin
               state     <= ST_STOPPED;
               running_q <= 1'b0;
               ovf_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.digits    = dig_q;
   assign bus.tick      = tick_w;
   assign bus.carry_out = top_ovf;
   assign bus.running   = running_q;
   assign bus.ovf       = ovf_q;

endmodule
